// File: rtl/inst_loader.sv
// -----------------------------------------------------------------------------
// inst_loader
//   Boot-time program loader sitting between a UART byte stream and a CPU.
//   The loader first receives a 4-byte big-endian word count N. It then
//   receives N instruction words, 4 bytes each and big-endian, and writes them
//   into a private instruction memory. While loading, the CPU is held in
//   reset. Once all N words are stored, the CPU is released, and the memory
//   serves registered instruction fetches with 1-cycle latency.
//
// Ports
//   clk             : sole clock, rising edge.
//   rstn            : asynchronous active-low reset. It does not touch memory
//                     contents.
//   byte_in         : received byte.
//   byte_valid      : one-cycle strobe; byte_in is valid this cycle.
//   reload          : one-cycle pulse; restarts the load from the count header.
//   program_counter : word address requested by the CPU.
//   inst            : registered instruction word. It reads 0 outside RUN and
//                     for addresses >= N.
//   cpu_rstn        : active-low reset driven to the CPU core.
//   loading         : high while receiving the count or the program words.
//   error           : high while the received count exceeds the memory size.
//   words_loaded    : number of words written so far.
// -----------------------------------------------------------------------------
module inst_loader #(
  parameter int ADDR_BITS = 10,
  parameter int WIDTH     = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  input  logic                 reload,
  input  logic [WIDTH-1:0]     program_counter,
  output logic [WIDTH-1:0]     inst,
  output logic                 cpu_rstn,
  output logic                 loading,
  output logic                 error,
  output logic [ADDR_BITS:0]   words_loaded
);

  typedef enum logic [1:0] {
    ST_LEN  = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam int          DEPTH     = 1 << ADDR_BITS;
  localparam logic [32:0] MAX_WORDS = 33'(DEPTH);

  state_t                 state_q, state_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic [23:0]            shift_q, shift_d;
  logic [31:0]            n_q, n_d;
  logic [ADDR_BITS:0]     words_loaded_q, words_loaded_d;
  logic                   wr_pend_q, wr_pend_d;
  logic [WIDTH-1:0]       wr_data_q, wr_data_d;
  logic [WIDTH-1:0]       inst_q, inst_d;
  logic                   cpu_rstn_q, cpu_rstn_d;
  logic                   loading_q, loading_d;
  logic                   error_q, error_d;

  logic [WIDTH-1:0]       mem [DEPTH];

  logic [31:0]            full_word_s;
  logic                   byte_take_s;
  logic                   wr_en_s;
  logic [ADDR_BITS-1:0]   wr_addr_s;
  logic [ADDR_BITS-1:0]   rd_addr_s;
  logic                   last_word_s;
  logic [WIDTH-1:0]       rd_data_s;

  // Datapath decode: assembled word, write enable/address, read path with write bypass
  always_comb begin
    full_word_s = {shift_q, byte_in};
    byte_take_s = byte_valid && ((state_q == ST_LEN) || (state_q == ST_LOAD));
    // A completed word waits one cycle in wr_data_q. A reload in that cycle drops it.
    wr_en_s     = wr_pend_q && (state_q == ST_LOAD) && !reload;
    wr_addr_s   = words_loaded_q[ADDR_BITS-1:0];
    last_word_s = ((32'(words_loaded_q) + 32'd1) == n_q);
    rd_addr_s   = program_counter[ADDR_BITS-1:0];
    // The final write and the first RUN fetch can land on the same edge.
    if (wr_en_s && (wr_addr_s == rd_addr_s)) begin
      rd_data_s = wr_data_q;
    end else begin
      rd_data_s = mem[rd_addr_s];
    end
  end

  // Next-state and next-output logic for the load/run state machine
  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    shift_d        = shift_q;
    n_d            = n_q;
    words_loaded_d = words_loaded_q;
    wr_pend_d      = 1'b0;
    wr_data_d      = wr_data_q;

    if (reload) begin
      // Reload wins over a same-cycle byte. Any partial or pending word is lost.
      state_d        = ST_LEN;
      byte_cnt_d     = 2'd0;
      shift_d        = 24'd0;
      n_d            = 32'd0;
      words_loaded_d = '0;
    end else begin
      if (wr_en_s) begin
        words_loaded_d = words_loaded_q + 1'b1;
        if (last_word_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = state_q;
        end
      end else begin
        words_loaded_d = words_loaded_q;
      end

      if (byte_take_s) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        shift_d    = {shift_q[15:0], byte_in};
        if (byte_cnt_q == 2'd3) begin
          case (state_q)
            ST_LEN: begin
              n_d = full_word_s;
              if ({1'b0, full_word_s} > MAX_WORDS) begin
                state_d = ST_ERR;
              end else if (full_word_s == 32'd0) begin
                state_d = ST_RUN;
              end else begin
                state_d = ST_LOAD;
              end
            end
            ST_LOAD: begin
              // Bytes arriving while the last word commits are discarded.
              if (!(wr_en_s && last_word_s)) begin
                wr_pend_d = 1'b1;
                wr_data_d = full_word_s;
              end else begin
                wr_pend_d = 1'b0;
              end
            end
            default: begin
              wr_pend_d = 1'b0;
            end
          endcase
        end else begin
          n_d = n_q;
        end
      end else begin
        byte_cnt_d = byte_cnt_q;
      end
    end

    cpu_rstn_d = (state_d == ST_RUN);
    loading_d  = (state_d == ST_LEN) || (state_d == ST_LOAD);
    error_d    = (state_d == ST_ERR);

    // The full-width pc takes part in the bound check. Only its low bits index memory.
    if ((state_d == ST_RUN) && (32'(program_counter) < n_d)) begin
      inst_d = rd_data_s;
    end else begin
      inst_d = '0;
    end
  end

  // State and output registers, cleared asynchronously by rstn
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_LEN;
      byte_cnt_q     <= 2'd0;
      shift_q        <= 24'd0;
      n_q            <= 32'd0;
      words_loaded_q <= '0;
      wr_pend_q      <= 1'b0;
      wr_data_q      <= '0;
      inst_q         <= '0;
      cpu_rstn_q     <= 1'b0;
      loading_q      <= 1'b1;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      shift_q        <= shift_d;
      n_q            <= n_d;
      words_loaded_q <= words_loaded_d;
      wr_pend_q      <= wr_pend_d;
      wr_data_q      <= wr_data_d;
      inst_q         <= inst_d;
      cpu_rstn_q     <= cpu_rstn_d;
      loading_q      <= loading_d;
      error_q        <= error_d;
    end
  end

  // Instruction memory write port; contents survive rstn and reload
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_addr_s] <= wr_data_q;
    end
  end

  assign inst         = inst_q;
  assign cpu_rstn     = cpu_rstn_q;
  assign loading      = loading_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_inst_loader.sv
// -----------------------------------------------------------------------------
// tb_inst_loader
//   Directed bench for inst_loader. Stimulus pushes expected values, each with
//   the cycle on which it must hold, into a scoreboard queue. A monitor pops
//   and compares them at the falling edge.
// -----------------------------------------------------------------------------
module tb_inst_loader;

  localparam int ADDR_BITS = 10;
  localparam int WIDTH     = 32;

  localparam int K_INST = 0;
  localparam int K_CRST = 1;
  localparam int K_LOAD = 2;
  localparam int K_ERR  = 3;
  localparam int K_WL   = 4;

  logic                 clk;
  logic                 rstn;
  logic [7:0]           byte_in;
  logic                 byte_valid;
  logic                 reload;
  logic [WIDTH-1:0]     program_counter;
  logic [WIDTH-1:0]     inst;
  logic                 cpu_rstn;
  logic                 loading;
  logic                 error;
  logic [ADDR_BITS:0]   words_loaded;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc          = 0;
  int   errors       = 0;
  int   checks       = 0;
  bit   drain_expired = 1'b0;

  inst_loader #(.ADDR_BITS(ADDR_BITS), .WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .byte_in         (byte_in),
    .byte_valid      (byte_valid),
    .reload          (reload),
    .program_counter (program_counter),
    .inst            (inst),
    .cpu_rstn        (cpu_rstn),
    .loading         (loading),
    .error           (error),
    .words_loaded    (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(int k);
    case (k)
      K_INST:  return inst;
      K_CRST:  return {31'd0, cpu_rstn};
      K_LOAD:  return {31'd0, loading};
      K_ERR:   return {31'd0, error};
      K_WL:    return 32'(words_loaded);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every expectation that has come due
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] a;
    while (sb.size() > 0 && (sb[0].due <= cyc || drain_expired)) begin
      e = sb.pop_front();
      checks = checks + 1;
      if (drain_expired && e.due > cyc) begin
        errors = errors + 1;
        $display("FAIL %s: never sampled (due cycle %0d, now %0d), required %h", e.name, e.due, cyc, e.exp);
      end else begin
        a = actual(e.kind);
        if (a !== e.exp) begin
          errors = errors + 1;
          $display("FAIL %s: got %h, required %h (cycle %0d)", e.name, a, e.exp, cyc);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input logic [31:0] exp, input string name, input int delay);
    exp_t e;
    e.due  = cyc + delay;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
    byte_in    = 8'h00;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24]);
      t = t << 8;
    end
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  task automatic read_pc(input logic [31:0] pc, input logic [31:0] exp, input string name);
    program_counter = pc;
    expect_val(K_INST, exp, name, 1);
    tick();
  endtask

  initial begin
    rstn            = 1'b0;
    byte_in         = 8'h00;
    byte_valid      = 1'b0;
    reload          = 1'b0;
    program_counter = 32'd0;

    // Reset state
    expect_val(K_INST, 32'd0, "rst_inst", 0);
    expect_val(K_CRST, 32'd0, "rst_cpu_rstn", 0);
    expect_val(K_LOAD, 32'd1, "rst_loading", 0);
    expect_val(K_ERR,  32'd0, "rst_error", 0);
    expect_val(K_WL,   32'd0, "rst_words", 0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    // Two-word program
    send_word(32'h0000_0002);
    expect_val(K_LOAD, 32'd1, "t1_loading_after_len", 0);
    expect_val(K_CRST, 32'd0, "t1_cpu_held", 0);
    send_word(32'h1234_5678);
    send_word(32'h9ABC_DEF0);
    expect_val(K_WL,   32'd1, "t1_words_before_last", 0);
    expect_val(K_LOAD, 32'd1, "t1_loading_before_last", 0);
    tick();
    expect_val(K_WL,   32'd2, "t1_words_loaded", 0);
    expect_val(K_LOAD, 32'd0, "t1_loading_run", 0);
    expect_val(K_CRST, 32'd1, "t1_cpu_rstn_run", 0);
    read_pc(32'd0, 32'h1234_5678, "t1_pc0");
    read_pc(32'd1, 32'h9ABC_DEF0, "t1_pc1");
    read_pc(32'd2, 32'h0000_0000, "t1_pc2");
    read_pc(32'h0000_0400, 32'h0000_0000, "t1_pc_high_bits");
    send_byte(8'h77);
    expect_val(K_WL, 32'd2, "t1_run_ignores_byte", 0);

    // Oversized count goes to ERR and stays there until reload
    pulse_reload();
    expect_val(K_LOAD, 32'd1, "t2_reload_loading", 0);
    expect_val(K_CRST, 32'd0, "t2_reload_cpu_rstn", 0);
    expect_val(K_WL,   32'd0, "t2_reload_words", 0);
    expect_val(K_INST, 32'd0, "t2_reload_inst", 0);
    send_word(32'h0000_0401);
    expect_val(K_ERR,  32'd1, "t2_error", 0);
    expect_val(K_CRST, 32'd0, "t2_err_cpu_rstn", 0);
    expect_val(K_INST, 32'd0, "t2_err_inst", 0);
    expect_val(K_LOAD, 32'd0, "t2_err_loading", 0);
    send_word(32'h0000_0001);
    expect_val(K_ERR,  32'd1, "t2_err_sticky", 0);
    pulse_reload();
    expect_val(K_LOAD, 32'd1, "t2_exit_loading", 0);
    expect_val(K_ERR,  32'd0, "t2_exit_error", 0);

    // Exactly 2^ADDR_BITS words is legal
    send_word(32'h0000_0400);
    expect_val(K_ERR,  32'd0, "t2_max_count_no_error", 0);
    expect_val(K_LOAD, 32'd1, "t2_max_count_loading", 0);
    send_byte(8'hEE);
    send_byte(8'hEE);
    pulse_reload();

    // Zero-length program
    send_word(32'h0000_0000);
    expect_val(K_CRST, 32'd1, "t3_zero_run", 0);
    expect_val(K_LOAD, 32'd0, "t3_zero_loading", 0);
    expect_val(K_WL,   32'd0, "t3_zero_words", 0);
    read_pc(32'd0, 32'h0000_0000, "t3_pc0");
    read_pc(32'd1, 32'h0000_0000, "t3_pc1");

    // Reload with a same-cycle byte: the byte must be discarded
    reload     = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    tick();
    reload     = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    expect_val(K_LOAD, 32'd1, "t4_reload_loading", 0);
    expect_val(K_CRST, 32'd0, "t4_reload_cpu_rstn", 0);
    send_word(32'h0000_0001);
    expect_val(K_ERR, 32'd0, "t4_count_ok", 0);
    send_word(32'hAABB_CCDD);
    tick();
    expect_val(K_CRST, 32'd1, "t4_run", 0);
    expect_val(K_WL,   32'd1, "t4_words", 0);
    read_pc(32'd0, 32'hAABB_CCDD, "t4_pc0");
    read_pc(32'd1, 32'h0000_0000, "t4_pc1");

    // rstn mid-word abandons the load and the partial word
    pulse_reload();
    send_word(32'h0000_0001);
    send_byte(8'h11);
    send_byte(8'h22);
    rstn = 1'b0;
    expect_val(K_LOAD, 32'd1, "t5_rst_loading", 0);
    expect_val(K_WL,   32'd0, "t5_rst_words", 0);
    expect_val(K_CRST, 32'd0, "t5_rst_cpu_rstn", 0);
    expect_val(K_INST, 32'd0, "t5_rst_inst", 0);
    tick();
    rstn = 1'b1;
    tick();
    send_word(32'h0000_0001);
    send_word(32'h3344_5566);
    tick();
    expect_val(K_CRST, 32'd1, "t5_run", 0);
    read_pc(32'd0, 32'h3344_5566, "t5_pc0");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) begin
      tick();
    end
    drain_expired = 1'b1;
    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
